// File: rtl/imm_pkg.sv
// Shared types for the immediate-decode stage: RV32I/RV64I major opcodes,
// the immediate-format tag carried with every decoded beat, and a small
// helper used by the optional CSR-immediate decode (IMM_DECODE_ZIMM_EN).
package imm_pkg;

    // Major opcodes (instr[6:0]) that the decoder recognises.
    typedef enum logic [6:0] {
        OPC_LOAD     = 7'b0000011,
        OPC_MISC_MEM = 7'b0001111,
        OPC_OP_IMM   = 7'b0010011,
        OPC_AUIPC    = 7'b0010111,
        OPC_STORE    = 7'b0100011,
        OPC_OP       = 7'b0110011,
        OPC_LUI      = 7'b0110111,
        OPC_BRANCH   = 7'b1100011,
        OPC_JALR     = 7'b1100111,
        OPC_JAL      = 7'b1101111,
        OPC_SYSTEM   = 7'b1110011
    } opcode_e;

    // Immediate format tag; encoding 6 is unused.
    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_Z    = 3'd5,
        IMM_NONE = 3'd7
    } imm_type_e;

    // Width of the instruction word, independent of XLEN.
    localparam int INSTR_W = 32;

    // CSRRWI / CSRRSI / CSRRCI carry a 5-bit unsigned immediate in rs1.
    function automatic logic is_csr_imm(input logic [2:0] funct3);
        return (funct3 == 3'b101) || (funct3 == 3'b110) || (funct3 == 3'b111);
    endfunction

endpackage

// File: rtl/imm_decode_comb.sv
// Purely combinational immediate decoder, parametrised by XLEN (32 or 64).
// Every format is first assembled as a 32-bit sign-extended value and then
// sign-extended once more to XLEN, so U-format immediates take bit 31 as
// their sign on RV64. Define IMM_DECODE_ZIMM_EN to decode the CSR*I zimm
// field; otherwise all SYSTEM instructions report IMM_NONE.
module imm_decode_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr_i,
    output logic [XLEN-1:0]    imm_o,
    output imm_type_e          imm_type_o,
    output logic               illegal_o
);

    logic [31:0] imm32;

    // Opcode decode: select the format, assemble the 32-bit immediate.
    always_comb begin
        imm32      = '0;
        imm_type_o = IMM_NONE;
        illegal_o  = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            // Compressed / reserved encodings are not handled by this stage.
            illegal_o = 1'b1;
        end else begin
            case (instr_i[6:0])
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    imm_type_o = IMM_I;
                    imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
                end
                OPC_STORE: begin
                    imm_type_o = IMM_S;
                    imm32      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                end
                OPC_BRANCH: begin
                    imm_type_o = IMM_B;
                    imm32      = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                                  instr_i[30:25], instr_i[11:8], 1'b0};
                end
                OPC_JAL: begin
                    imm_type_o = IMM_J;
                    imm32      = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                                  instr_i[20], instr_i[30:21], 1'b0};
                end
                OPC_LUI, OPC_AUIPC: begin
                    imm_type_o = IMM_U;
                    imm32      = {instr_i[31:12], 12'b0};
                end
                OPC_OP, OPC_MISC_MEM: begin
                    // Register-only formats: no immediate, still legal.
                    imm_type_o = IMM_NONE;
                end
                OPC_SYSTEM: begin
`ifdef IMM_DECODE_ZIMM_EN
                    if (is_csr_imm(instr_i[14:12])) begin
                        imm_type_o = IMM_Z;
                        imm32      = {27'b0, instr_i[19:15]};
                    end
`endif
                end
                default: begin
                    // Unknown opcode: tag it and let the beat flow on.
                    illegal_o = 1'b1;
                end
            endcase
        end
    end

    // Final sign extension to the datapath width. zimm has bit 31 clear,
    // so the same extension leaves it zero-extended.
    generate
        if (XLEN == 32) begin : g_xlen32
            assign imm_o = imm32;
        end else begin : g_xlen_wide
            assign imm_o = {{(XLEN-32){imm32[31]}}, imm32};
        end
    endgenerate

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage between fetch and execute. Incoming
// beats are decoded combinationally and stored in a main register (which
// drives the outputs) backed by a one-entry skid register, giving full
// throughput with a registered in_ready. flush empties both entries.
// The optional CSR-immediate decode is enabled by IMM_DECODE_ZIMM_EN.
module imm_decode_stage
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_imm,
    output imm_type_e          out_imm_type,
    output logic               out_illegal
);

    // One decoded beat as it travels through the stage.
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    imm;
        imm_type_e          imm_type;
        logic               illegal;
    } beat_t;

    localparam beat_t BEAT_RESET = '{
        instr:    '0,
        pc:       '0,
        imm:      '0,
        imm_type: IMM_NONE,
        illegal:  1'b0
    };

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    state_e          state_q;
    beat_t           main_q;
    beat_t           skid_q;
    logic            in_ready_q;

    beat_t           beat_d;
    logic [XLEN-1:0] dec_imm;
    imm_type_e       dec_type;
    logic            dec_illegal;
    logic            accept;
    logic            drain;

    imm_decode_comb #(
        .XLEN (XLEN)
    ) u_decode (
        .instr_i    (in_instr),
        .imm_o      (dec_imm),
        .imm_type_o (dec_type),
        .illegal_o  (dec_illegal)
    );

    // Assemble the incoming beat from the raw inputs and the decoder.
    always_comb begin
        beat_d          = BEAT_RESET;
        beat_d.instr    = in_instr;
        beat_d.pc       = in_pc;
        beat_d.imm      = dec_imm;
        beat_d.imm_type = dec_type;
        beat_d.illegal  = dec_illegal;
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid & out_ready;

    // Skid-buffer FSM; in_ready_q tracks "next state is not TWO".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            main_q     <= BEAT_RESET;
            skid_q     <= BEAT_RESET;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            // Redirect: drop held entries and any beat offered this cycle.
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        main_q  <= beat_d;
                        state_q <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_q <= beat_d;
                    end else if (accept) begin
                        // Downstream stalled: park the new beat behind main.
                        skid_q     <= beat_d;
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (drain) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        main_q     <= skid_q;
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q != ST_EMPTY);
    assign out_instr    = main_q.instr;
    assign out_pc       = main_q.pc;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_illegal  = main_q.illegal;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Scoreboard bench for imm_decode_stage: one XLEN=32 and one XLEN=64
// instance. Directed beats push hand-computed expectations into queues;
// monitors pop and compare whenever a beat drains.
module tb_imm_decode_stage;
    import imm_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    // XLEN=32 instance signals
    logic        flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, in_pc, out_instr, out_pc, out_imm;
    imm_type_e   out_imm_type;

    // XLEN=64 instance signals
    logic        w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_out_illegal;
    logic [31:0] w_in_instr, w_out_instr;
    logic [63:0] w_in_pc, w_out_pc, w_out_imm;
    imm_type_e   w_out_imm_type;

    exp_t q32[$];
    exp_t q64[$];
    exp_t e32;
    exp_t e64;

    imm_decode_stage #(.XLEN(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .out_imm(out_imm),
        .out_imm_type(out_imm_type), .out_illegal(out_illegal)
    );

    imm_decode_stage #(.XLEN(64)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_instr(w_in_instr), .in_pc(w_in_pc),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out_instr(w_out_instr), .out_pc(w_out_pc), .out_imm(w_out_imm),
        .out_imm_type(w_out_imm_type), .out_illegal(w_out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Offer one beat to the 32-bit stage; expectation is queued when accepted.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [2:0] ty, input logic ill);
        exp_t e;
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                e.instr = instr; e.pc = {32'b0, pc}; e.imm = {32'b0, imm};
                e.ty = ty; e.ill = ill;
                q32.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send32_timeout", 64'd1, 64'd0);
        in_valid = 1'b0;
    endtask

    task automatic send64(input logic [31:0] instr, input logic [63:0] pc,
                          input logic [63:0] imm, input logic [2:0] ty, input logic ill);
        exp_t e;
        w_in_valid = 1'b1;
        w_in_instr = instr;
        w_in_pc    = pc;
        for (int i = 0; i < 50; i++) begin
            if (w_in_ready) begin
                e.instr = instr; e.pc = pc; e.imm = imm; e.ty = ty; e.ill = ill;
                q64.push_back(e);
                @(posedge clk); #1;
                w_in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        chk("send64_timeout", 64'd1, 64'd0);
        w_in_valid = 1'b0;
    endtask

    task automatic wait_drain;
        for (int i = 0; i < 60; i++) begin
            if (q32.size() == 0 && q64.size() == 0 && !out_valid && !w_out_valid) return;
            @(posedge clk); #1;
        end
        chk("drain_timeout", 64'(q32.size() + q64.size()), 64'd0);
    endtask

    // Monitor for the 32-bit stage.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q32.size() == 0) begin
                chk("x32_unexpected_beat", {32'b0, out_instr}, 64'hDEAD);
            end else begin
                e32 = q32.pop_front();
                $display("x32 beat instr=%h pc=%h imm=%h type=%0d ill=%0d",
                         out_instr, out_pc, out_imm, out_imm_type, out_illegal);
                chk("x32_instr", {32'b0, out_instr}, {32'b0, e32.instr});
                chk("x32_pc", {32'b0, out_pc}, e32.pc);
                chk("x32_imm", {32'b0, out_imm}, e32.imm);
                chk("x32_type", 64'(out_imm_type), 64'(e32.ty));
                chk("x32_illegal", 64'(out_illegal), 64'(e32.ill));
            end
        end
    end

    // Monitor for the 64-bit stage.
    always @(negedge clk) begin
        if (rst_n && w_out_valid && w_out_ready) begin
            if (q64.size() == 0) begin
                chk("x64_unexpected_beat", {32'b0, w_out_instr}, 64'hDEAD);
            end else begin
                e64 = q64.pop_front();
                $display("x64 beat instr=%h pc=%h imm=%h type=%0d ill=%0d",
                         w_out_instr, w_out_pc, w_out_imm, w_out_imm_type, w_out_illegal);
                chk("x64_instr", {32'b0, w_out_instr}, {32'b0, e64.instr});
                chk("x64_pc", w_out_pc, e64.pc);
                chk("x64_imm", w_out_imm, e64.imm);
                chk("x64_type", 64'(w_out_imm_type), 64'(e64.ty));
                chk("x64_illegal", 64'(w_out_illegal), 64'(e64.ill));
            end
        end
    end

    logic [31:0] zimm_exp;
    logic [2:0]  zty_exp;
    int          c0;

    initial begin
`ifdef IMM_DECODE_ZIMM_EN
        zimm_exp = 32'd5;  zty_exp = IMM_Z;
`else
        zimm_exp = 32'd0;  zty_exp = IMM_NONE;
`endif
        total = 0; bad = 0; cyc = 0;
        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
        w_flush = 1'b0; w_in_valid = 1'b0; w_in_instr = '0; w_in_pc = '0; w_out_ready = 1'b1;

        // Reset values
        repeat (2) @(posedge clk);
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_imm", {32'b0, out_imm}, 64'd0);
        chk("rst_out_pc", {32'b0, out_pc}, 64'd0);
        chk("rst_out_instr", {32'b0, out_instr}, 64'd0);
        chk("rst_out_type", 64'(out_imm_type), 64'(IMM_NONE));
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst64_out_imm", w_out_imm, 64'd0);
        rst_n = 1'b1;

        // First beat accepted on the first edge after release; 1-cycle latency.
        send(32'hFFF00093, 32'h0000_1000, 32'hFFFF_FFFF, IMM_I, 1'b0);
        chk("latency_out_valid", 64'(out_valid), 64'd1);

        // Back-to-back stream, one beat per cycle.
        c0 = cyc;
        send(32'hFE000EE3, 32'h0000_1004, 32'hFFFF_FFFC, IMM_B, 1'b0);  // beq -4
        send(32'hFE000FE3, 32'h0000_1008, 32'hFFFF_FFFE, IMM_B, 1'b0);  // beq -2
        send(32'h123452B7, 32'h0000_100C, 32'h1234_5000, IMM_U, 1'b0);  // lui
        send(32'hFE512C23, 32'h0000_1010, 32'hFFFF_FFF8, IMM_S, 1'b0);  // sw -8
        send(32'h001000EF, 32'h0000_1014, 32'h0000_0800, IMM_J, 1'b0);  // jal +2048
        send(32'h003100B3, 32'h0000_1018, 32'h0000_0000, IMM_NONE, 1'b0); // add
        send(32'h80000297, 32'h0000_101C, 32'h8000_0000, IMM_U, 1'b0);  // auipc
        send(32'h00000073, 32'h0000_1020, 32'h0000_0000, IMM_NONE, 1'b0); // ecall
        send(32'h3002D073, 32'h0000_1024, zimm_exp, zty_exp, 1'b0);     // csrrwi
        send(32'h00000000, 32'h0000_1028, 32'h0000_0000, IMM_NONE, 1'b1);
        send(32'h0000007F, 32'h0000_102C, 32'h0000_0000, IMM_NONE, 1'b1);
        send(32'hFFF00091, 32'h0000_1030, 32'h0000_0000, IMM_NONE, 1'b1);
        chk("throughput_cycles", 64'(cyc - c0), 64'd12);
        wait_drain();

        // Backpressure: A, B held; C waits upstream until drain resumes.
        out_ready = 1'b0;
        send(32'h00500113, 32'h0000_2000, 32'h0000_0005, IMM_I, 1'b0);  // A
        send(32'h00A00193, 32'h0000_2004, 32'h0000_000A, IMM_I, 1'b0);  // B
        chk("ready_after_B", 64'(in_ready), 64'd0);
        fork
            send(32'hFF000213, 32'h0000_2008, 32'hFFFF_FFF0, IMM_I, 1'b0); // C
            begin
                repeat (3) begin
                    chk("stall_in_ready", 64'(in_ready), 64'd0);
                    chk("stall_hold_instr", {32'b0, out_instr}, 64'h0050_0113);
                    @(posedge clk); #2;
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Flush in TWO with a beat offered: everything is discarded.
        out_ready = 1'b0;
        send(32'h00100293, 32'h0000_3000, 32'h0000_0001, IMM_I, 1'b0);
        send(32'h00200313, 32'h0000_3004, 32'h0000_0002, IMM_I, 1'b0);
        chk("two_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b1; in_instr = 32'h00300393; in_pc = 32'h0000_3008; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'd0);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        q32.delete();
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send(32'h00400413, 32'h0000_300C, 32'h0000_0004, IMM_I, 1'b0);
        wait_drain();

        // Asynchronous reset mid-cycle discards held beats immediately.
        out_ready = 1'b0;
        send(32'h00700493, 32'h0000_4000, 32'h0000_0007, IMM_I, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_out_imm", {32'b0, out_imm}, 64'd0);
        chk("async_rst_in_ready", 64'(in_ready), 64'd1);
        q32.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        out_ready = 1'b1;

        // XLEN=64 sign extension.
        send64(32'h80000297, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_8000_0000, IMM_U, 1'b0);
        send64(32'hFFF00093, 64'h0000_0001_0000_0004, 64'hFFFF_FFFF_FFFF_FFFF, IMM_I, 1'b0);
        send64(32'h123452B7, 64'h0000_0001_0000_0008, 64'h0000_0000_1234_5000, IMM_U, 1'b0);
        send64(32'hFE000EE3, 64'h0000_0001_0000_000C, 64'hFFFF_FFFF_FFFF_FFFC, IMM_B, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
